cpu_6502_psr: RTL and testbench

Processor status unit for the 2A03 core, sitting on the result side of the ALU. It holds the P register and folds ALU N/Z/C/V results into it under per-flag write enables. It handles flag set/clear instructions, PLP/RTI pulls and PHP/BRK push images. It also does branch-condition evaluation, NMI edge detection and IRQ masking, and feeds the carry back to the ALU.

---
 rtl/cpu_6502_psr.sv | 134 +++++++++++++
 tb/tb_cpu_6502_psr.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_6502_psr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_6502_psr : 2A03 processor status register, branch condition, NMI/IRQ gate
// Optional: CPU_6502_IRQ_DELAY_EN registers the IRQ mask (one-instruction lag)
// Revision: 1.0
// ----------------------------------------------------------------------------
module cpu_6502_psr #(
  parameter logic [7:0] P_RESET = 8'h34
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_ce,
  input  logic       i_alu_n,
  input  logic       i_alu_z,
  input  logic       i_alu_c,
  input  logic       i_alu_v,
  input  logic [3:0] i_nzcv_we,
  input  logic [2:0] i_set_op,
  input  logic       i_int_seti,
  input  logic       i_pull_we,
  input  logic [7:0] i_pull_data,
  input  logic       i_push_brk,
  input  logic [2:0] i_br_sel,
  input  logic       i_nmi_n,
  input  logic       i_irq_n,
  input  logic       i_poll,
  input  logic       i_nmi_ack,
  output logic [7:0] o_p,
  output logic [7:0] o_push_data,
  output logic       o_c,
  output logic       o_br_taken,
  output logic       o_nmi_pend,
  output logic       o_irq_take
);

  localparam logic [2:0] SET_CLC = 3'd1;
  localparam logic [2:0] SET_SEC = 3'd2;
  localparam logic [2:0] SET_CLI = 3'd3;
  localparam logic [2:0] SET_SEI = 3'd4;
  localparam logic [2:0] SET_CLV = 3'd5;
  localparam logic [2:0] SET_CLD = 3'd6;
  localparam logic [2:0] SET_SED = 3'd7;

  localparam int BIT_C = 0;
  localparam int BIT_Z = 1;
  localparam int BIT_I = 2;
  localparam int BIT_D = 3;
  localparam int BIT_V = 6;
  localparam int BIT_N = 7;

  logic [7:0] p_q, p_d;
  logic [7:0] pull_img;
  logic       nmi_prev_q;
  logic       nmi_pend_q, nmi_pend_d;
  logic       irq_mask;
  logic       br_flag;

  // Bits 5 and 4 are not storage; they are forced high on every path.
  assign pull_img = (i_pull_data & 8'hCF) | 8'h30;

  always_comb begin
    p_d = p_q;
    if (i_pull_we) begin
      p_d = pull_img;
    end else begin
      p_d[BIT_N] = i_nzcv_we[3] ? i_alu_n : p_q[BIT_N];
      p_d[BIT_Z] = i_nzcv_we[1] ? i_alu_z : p_q[BIT_Z];

      if (i_set_op == SET_CLC)      p_d[BIT_C] = 1'b0;
      else if (i_set_op == SET_SEC) p_d[BIT_C] = 1'b1;
      else if (i_nzcv_we[0])        p_d[BIT_C] = i_alu_c;

      if (i_set_op == SET_CLV)      p_d[BIT_V] = 1'b0;
      else if (i_nzcv_we[2])        p_d[BIT_V] = i_alu_v;

      if (i_set_op == SET_CLD)      p_d[BIT_D] = 1'b0;
      else if (i_set_op == SET_SED) p_d[BIT_D] = 1'b1;

      if (i_int_seti)               p_d[BIT_I] = 1'b1;
      else if (i_set_op == SET_CLI) p_d[BIT_I] = 1'b0;
      else if (i_set_op == SET_SEI) p_d[BIT_I] = 1'b1;
    end
  end

  // An edge arriving with the ack wins so that a fresh NMI is never dropped.
  assign nmi_pend_d = (nmi_prev_q & ~i_nmi_n) | (nmi_pend_q & ~i_nmi_ack);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      p_q        <= P_RESET | 8'h30;
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else if (i_ce) begin
      p_q        <= p_d;
      nmi_prev_q <= i_nmi_n;
      nmi_pend_q <= nmi_pend_d;
    end
  end

`ifdef CPU_6502_IRQ_DELAY_EN
  logic irq_mask_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      irq_mask_q <= 1'b1;
    end else if (i_ce && i_poll) begin
      irq_mask_q <= p_q[BIT_I];
    end
  end

  assign irq_mask = irq_mask_q;
`else
  assign irq_mask = p_q[BIT_I];
`endif

  // opcode[7:6] picks the flag, opcode[5] the polarity that takes the branch.
  always_comb begin
    case (i_br_sel[2:1])
      2'd0:    br_flag = p_q[BIT_N];
      2'd1:    br_flag = p_q[BIT_V];
      2'd2:    br_flag = p_q[BIT_C];
      default: br_flag = p_q[BIT_Z];
    endcase
  end

  assign o_br_taken  = (br_flag == i_br_sel[0]);
  assign o_p         = p_q | 8'h30;
  assign o_c         = p_q[BIT_C];
  assign o_push_data = {p_q[7:6], 1'b1, i_push_brk, p_q[3:0]};
  assign o_nmi_pend  = nmi_pend_q;
  assign o_irq_take  = i_poll & ~i_irq_n & ~irq_mask & ~nmi_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_6502_psr.sv
`default_nettype none
// Randomized scoreboard bench for cpu_6502_psr against a flag-level reference model.
module tb_cpu_6502_psr;

  logic       clk = 1'b0;
  logic       rstn, ce, alu_n, alu_z, alu_c, alu_v;
  logic [3:0] nzcv_we;
  logic [2:0] set_op, br_sel;
  logic       int_seti, pull_we, push_brk, nmi_n, irq_n, poll, nmi_ack;
  logic [7:0] pull_data;
  logic [7:0] o_p, o_push_data;
  logic       o_c, o_br_taken, o_nmi_pend, o_irq_take;

  always #5 clk = ~clk;

  cpu_6502_psr dut (
    .i_clk(clk), .i_rstn(rstn), .i_ce(ce),
    .i_alu_n(alu_n), .i_alu_z(alu_z), .i_alu_c(alu_c), .i_alu_v(alu_v),
    .i_nzcv_we(nzcv_we), .i_set_op(set_op), .i_int_seti(int_seti),
    .i_pull_we(pull_we), .i_pull_data(pull_data), .i_push_brk(push_brk),
    .i_br_sel(br_sel), .i_nmi_n(nmi_n), .i_irq_n(irq_n), .i_poll(poll),
    .i_nmi_ack(nmi_ack),
    .o_p(o_p), .o_push_data(o_push_data), .o_c(o_c), .o_br_taken(o_br_taken),
    .o_nmi_pend(o_nmi_pend), .o_irq_take(o_irq_take)
  );

  typedef struct {
    logic [7:0] p;
    logic       c;
    logic       br;
    logic [7:0] push;
    logic       take;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference state: P as a byte, NMI sampler, IRQ mask
  logic [7:0] m_p;
  logic       m_prev, m_pend, m_mask;
  logic       nmi_lvl = 1'b1;
  logic       irq_lvl = 1'b1;

  task automatic model_reset();
    m_p    = 8'h34;
    m_prev = 1'b1;
    m_pend = 1'b0;
    m_mask = 1'b1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("o_p",         o_p,                 e.p);
      chk("o_c",         {7'd0, o_c},         {7'd0, e.c});
      chk("o_br_taken",  {7'd0, o_br_taken},  {7'd0, e.br});
      chk("o_push_data", o_push_data,         e.push);
      chk("o_irq_take",  {7'd0, o_irq_take},  {7'd0, e.take});
      chk("o_nmi_pend",  {7'd0, o_nmi_pend},  {7'd0, e.pend});
    end
  end

  // alu = {n,v,z,c} aligned with we = {N,V,Z,C}
  task automatic step(input logic r, input logic en, input logic [3:0] we,
                      input logic [3:0] alu, input logic [2:0] sop,
                      input logic seti, input logic pl, input logic [7:0] pd,
                      input logic brk, input logic [2:0] br, input logic pol,
                      input logic ack);
    exp_t       e;
    logic [7:0] np;
    logic       flag, mask_now;
    int         pos[4] = '{0, 1, 6, 7};
    @(posedge clk);
    #1;
    rstn = r; ce = en; nzcv_we = we;
    {alu_n, alu_v, alu_z, alu_c} = alu;
    set_op = sop; int_seti = seti; pull_we = pl; pull_data = pd;
    push_brk = brk; br_sel = br; nmi_n = nmi_lvl; irq_n = irq_lvl;
    poll = pol; nmi_ack = ack;

    if (!r) model_reset();

    case (br / 2)
      0:       flag = m_p[7];
      1:       flag = m_p[6];
      2:       flag = m_p[0];
      default: flag = m_p[1];
    endcase
`ifdef CPU_6502_IRQ_DELAY_EN
    mask_now = m_mask;
`else
    mask_now = m_p[2];
`endif
    e.p    = m_p;
    e.c    = m_p[0];
    e.br   = (flag == (br % 2 == 1));
    e.push = {m_p[7:6], 1'b1, brk, m_p[3:0]};
    e.take = pol && !irq_lvl && !mask_now && !m_pend;
    e.pend = m_pend;
    q.push_back(e);

    if (r && en) begin
      if (pol) m_mask = m_p[2];
      if (pl) begin
        np = {pd[7:6], 2'b11, pd[3:0]};
      end else begin
        np = m_p;
        for (int i = 0; i < 4; i++)
          if (we[i]) np[pos[i]] = alu[i];
        case (sop)
          3'd1: np[0] = 1'b0;
          3'd2: np[0] = 1'b1;
          3'd3: np[2] = 1'b0;
          3'd4: np[2] = 1'b1;
          3'd5: np[6] = 1'b0;
          3'd6: np[3] = 1'b0;
          3'd7: np[3] = 1'b1;
          default: ;
        endcase
        if (seti) np[2] = 1'b1;
      end
      m_p = np;
      if (m_prev && !nmi_lvl) m_pend = 1'b1;
      else if (ack)           m_pend = 1'b0;
      m_prev = nmi_lvl;
    end
  endtask

  task automatic nop(input logic [2:0] br = 3'd0, input logic brk = 1'b0,
                     input logic pol = 1'b0, input logic ack = 1'b0,
                     input logic en = 1'b1);
    step(1'b1, en, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd0, brk, br, pol, ack);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic pull(input logic [7:0] d, input logic seti = 1'b0);
    step(1'b1, 1'b1, 4'd0, 4'd0, 3'd0, seti, 1'b1, d, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic setop(input logic [2:0] s, input logic seti = 1'b0);
    step(1'b1, 1'b1, 4'd0, 4'd0, s, seti, 1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; ce = 1'b0; nzcv_we = '0; {alu_n, alu_v, alu_z, alu_c} = '0;
    set_op = '0; int_seti = 1'b0; pull_we = 1'b0; pull_data = '0;
    push_brk = 1'b0; br_sel = '0; nmi_n = 1'b1; irq_n = 1'b1; poll = 1'b0;
    nmi_ack = 1'b0;
    model_reset();

    do_reset(); do_reset();
    nop(3'd0, 1'b1);
    pull(8'hFF); nop();
    pull(8'h00); nop();

    // ALU fold with per-flag enables, then the same cycle with CLC
    do_reset();
    step(1'b1, 1'b1, 4'b1011, 4'b1101, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    nop();
    do_reset();
    step(1'b1, 1'b1, 4'b1011, 4'b1101, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    nop();
    step(1'b1, 1'b1, 4'b0001, 4'b0001, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    nop();

    // Branch conditions and push image
    pull(8'h35); nop(3'd5); nop(3'd4);
    pull(8'h36); nop(3'd7, 1'b1);
    for (int b = 0; b < 8; b++) nop(3'(b));

    // NMI edge, held-low line, ack, coincident edge+ack, ce gating
    nmi_lvl = 1'b1; nop();
    nmi_lvl = 1'b0; nop(); nop();
    for (int i = 0; i < 10; i++) nop(3'd0, 1'b0, 1'b0, (i == 3));
    nmi_lvl = 1'b1; nop();
    nmi_lvl = 1'b0; nop(3'd0, 1'b0, 1'b0, 1'b1); nop(); nop(3'd0, 1'b0, 1'b0, 1'b1);
    nmi_lvl = 1'b1; nop(); nmi_lvl = 1'b0;
    nop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0); nop(3'd0, 1'b0, 1'b0, 1'b0, 1'b0); nop();
    nop(3'd0, 1'b0, 1'b0, 1'b1); nop();

    // IRQ level with CLI latency
    irq_lvl = 1'b0;
    setop(3'd4); nop(3'd0, 1'b0, 1'b1);
    setop(3'd3);
    nop(3'd0, 1'b0, 1'b1); nop(3'd0, 1'b0, 1'b1); nop(3'd0, 1'b0, 1'b1);
    irq_lvl = 1'b1; nop(3'd0, 1'b0, 1'b1);

    // I-flag priorities
    setop(3'd3, 1'b1); nop();
    pull(8'h00, 1'b1); nop();

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] sop;
      if ($urandom_range(0, 7) == 0) nmi_lvl = ~nmi_lvl;
      if ($urandom_range(0, 5) == 0) irq_lvl = ~irq_lvl;
      sop = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           sop,
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
